// File: rtl/mac_seq_ctrl_if.sv
// Handshake/bus bundle for mac_seq_ctrl: job control, operand stream and result stream.
interface mac_seq_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = 24
) ();
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic                  abort;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  result;
    logic                  overflow;

    modport master (
        output start, len, abort, in_valid, op_a, op_b, out_ready,
        input  busy, in_ready, out_valid, result, overflow
    );

    modport slave (
        input  start, len, abort, in_valid, op_a, op_b, out_ready,
        output busy, in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequenced multiply-accumulate job controller: streams len operand pairs, returns their dot product.
// Define MAC_SEQ_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH  = 24
) (
    input  logic           clk,
    input  logic           reset,
    mac_seq_ctrl_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_abort;
    logic [PROD_W-1:0]     w_prod;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_carry;
    logic [ACC_WIDTH-1:0]  w_acc_nxt;

    assign w_accept = (r_state == S_RUN) && bus.in_valid;
    assign w_abort  = (r_state != S_IDLE) && bus.abort;

    // Stage 2: product of the registered pair added into the accumulator with carry-out.
    assign w_prod  = PROD_W'(r_a) * PROD_W'(r_b);
    assign w_sum   = SUM_W'(r_acc) + SUM_W'(w_prod);
    assign w_carry = w_sum[ACC_WIDTH];
`ifdef MAC_SEQ_SAT_EN
    // Once clamped, any further add carries again (or adds zero), so the clamp holds for the job.
    assign w_acc_nxt = w_carry ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && (r_rem == LEN_WIDTH'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = bus.abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (bus.abort || bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Beat capture, remaining count and accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem      <= '0;
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_abort) begin
            r_rem      <= '0;
            r_s1_valid <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_a   <= bus.op_a;
                r_b   <= bus.op_b;
                r_rem <= r_rem - LEN_WIDTH'(1);
            end
            if ((r_state == S_IDLE) && bus.start) begin
                r_rem <= bus.len;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_s1_valid) begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | w_carry;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = (r_state == S_RUN);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_acc;
    assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: job-level reference model plus directed and random jobs.
module tb_mac_seq_ctrl;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = 16;
    localparam longint AMAX = (longint'(1) << AW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) bus ();

    mac_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model: a job is a length, a count of taken beats, an exact integer sum,
    // and the cycle from which its result must be presented.
    int     cyc = 0;
    bit     m_active = 1'b0;
    int     m_len = 0;
    int     m_cnt = 0;
    int     m_ready = 0;
    longint m_sum = 0;

    function automatic bit exp_ov(input int c);
        return m_active && (m_cnt == m_len) && (c >= m_ready);
    endfunction

    function automatic longint exp_res();
`ifdef MAC_SEQ_SAT_EN
        return (m_sum > AMAX) ? AMAX : m_sum;
`else
        return m_sum & AMAX;
`endif
    endfunction

    always @(posedge clk) begin
        bit hs;
        cyc++;
        hs = exp_ov(cyc - 1) && (bus.out_ready === 1'b1);
        if (reset) begin
            m_active = 1'b0;
        end else if (m_active && bus.abort) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active = 1'b1;
                m_len    = int'(bus.len);
                m_cnt    = 0;
                m_sum    = 0;
                m_ready  = cyc;
            end
        end else if (hs) begin
            m_active = 1'b0;
        end else if ((m_cnt < m_len) && bus.in_valid) begin
            m_sum += longint'(bus.op_a) * longint'(bus.op_b);
            m_cnt++;
            if (m_cnt == m_len) m_ready = cyc + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        chk("busy", 64'(bus.busy), 64'(m_active));
        chk("in_ready", 64'(bus.in_ready), 64'(m_active && (m_cnt < m_len)));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov(cyc)));
        if (exp_ov(cyc)) begin
            chk("result", 64'(bus.result), 64'(exp_res()));
            chk("overflow", 64'(bus.overflow), 64'(m_sum > AMAX));
        end
    end

    logic [DW-1:0] ja [0:15];
    logic [DW-1:0] jb [0:15];

    task automatic run_job(input int l, input int gap_mode, input int rdy_delay,
                           input bit start_in_done, input int abort_at,
                           output logic [AW-1:0] res, output logic ovf, output bit got,
                           output int lat, output bit saw_ready);
        int i = 0;
        int guard = 0;
        int k;
        got = 1'b0; saw_ready = 1'b0; lat = -1; res = '0; ovf = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(l); bus.out_ready = (rdy_delay == 0);
        @(negedge clk);
        bus.start = 1'b0;
        while ((i < l) && (guard < 400)) begin
            if (i == abort_at) begin
                bus.abort = 1'b1; bus.in_valid = 1'b0;
                @(negedge clk);
                bus.abort = 1'b0;
                return;
            end
            bus.op_a = ja[i]; bus.op_b = jb[i];
            case (gap_mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = ($urandom_range(0, 2) != 0);
                default: bus.in_valid = ((guard % 2) == 0);
            endcase
            #1;
            if (bus.in_valid && bus.in_ready) i++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        if (i < l) begin
            chk("beats_accepted", 64'(i), 64'(l));
            return;
        end
        for (k = 1; k < 40; k++) begin
            saw_ready |= bus.in_ready;
            if (bus.out_valid) break;
            @(negedge clk);
        end
        if (bus.out_valid !== 1'b1) begin
            chk("out_valid_timeout", 64'(0), 64'(1));
            return;
        end
        got = 1'b1; lat = k; res = bus.result; ovf = bus.overflow;
        for (int d = 0; d < rdy_delay; d++) begin
            if (start_in_done) bus.start = d[0];
            bus.len = LW'(2);
            @(negedge clk);
        end
        bus.start = start_in_done; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.start = 1'b0;
    endtask

    logic [AW-1:0] res;
    logic          ovf;
    bit            got;
    bit            sawr;
    int            lat;
    int            nov;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0; bus.in_valid = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_overflow", 64'(bus.overflow), 64'(0));

        // Back-to-back dot product with immediate consumption.
        ja[0] = 8'd2; jb[0] = 8'd3; ja[1] = 8'd4; jb[1] = 8'd5; ja[2] = 8'd6; jb[2] = 8'd7;
        run_job(3, 0, 0, 1'b0, -1, res, ovf, got, lat, sawr);
        chk("job3_got", 64'(got), 64'(1));
        chk("job3_result", 64'(res), 64'(68));
        chk("job3_overflow", 64'(ovf), 64'(0));
        chk("job3_latency", 64'(lat), 64'(2));

        // Empty job.
        run_job(0, 0, 0, 1'b0, -1, res, ovf, got, lat, sawr);
        chk("len0_got", 64'(got), 64'(1));
        chk("len0_result", 64'(res), 64'(0));
        chk("len0_overflow", 64'(ovf), 64'(0));
        chk("len0_in_ready", 64'(sawr), 64'(0));

        // Toggled in_valid, consumer stalls 5 cycles, start pulses while done.
        for (int i = 0; i < 4; i++) begin ja[i] = 8'd1; jb[i] = 8'd1; end
        run_job(4, 2, 5, 1'b1, -1, res, ovf, got, lat, sawr);
        chk("toggle_result", 64'(res), 64'(4));
        chk("toggle_overflow", 64'(ovf), 64'(0));
        @(negedge clk);
        chk("start_in_done_ignored", 64'(bus.busy), 64'(0));

        // Overflow.
        ja[0] = 8'd255; jb[0] = 8'd255; ja[1] = 8'd255; jb[1] = 8'd255;
        run_job(2, 0, 1, 1'b0, -1, res, ovf, got, lat, sawr);
        chk("ovf_flag", 64'(ovf), 64'(1));
`ifdef MAC_SEQ_SAT_EN
        chk("ovf_result", 64'(res), 64'(65535));
`else
        chk("ovf_result", 64'(res), 64'(64514));
`endif

        // Abort after two beats, then a fresh single-beat job.
        for (int i = 0; i < 5; i++) begin ja[i] = 8'd9; jb[i] = 8'd9; end
        run_job(5, 0, 0, 1'b0, 2, res, ovf, got, lat, sawr);
        chk("abort_no_result", 64'(got), 64'(0));
        nov = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) nov++;
        end
        chk("abort_out_valid_cnt", 64'(nov), 64'(0));
        ja[0] = 8'd3; jb[0] = 8'd3;
        run_job(1, 0, 0, 1'b0, -1, res, ovf, got, lat, sawr);
        chk("after_abort_result", 64'(res), 64'(9));
        chk("after_abort_overflow", 64'(ovf), 64'(0));

        // Reset while in RUN.
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(3);
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.op_a = 8'd200; bus.op_b = 8'd200;
        @(negedge clk);
        bus.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst_run_busy", 64'(bus.busy), 64'(0));
        chk("rst_run_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_run_result", 64'(bus.result), 64'(0));
        chk("rst_run_overflow", 64'(bus.overflow), 64'(0));
        reset = 1'b0;

        // Reset while in DRAIN.
        bus.start = 1'b1; bus.len = LW'(1);
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.op_a = 8'd5; bus.op_b = 8'd5;
        @(negedge clk);
        bus.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst_drain_busy", 64'(bus.busy), 64'(0));
        chk("rst_drain_result", 64'(bus.result), 64'(0));
        reset = 1'b0;
        ja[0] = 8'd7; jb[0] = 8'd8;
        run_job(1, 0, 0, 1'b0, -1, res, ovf, got, lat, sawr);
        chk("after_reset_result", 64'(res), 64'(56));

        // Random jobs checked cycle by cycle against the model.
        for (int j = 0; j < 60; j++) begin
            int l;
            int ab;
            l = $urandom_range(0, 8);
            for (int i = 0; i < 16; i++) begin
                ja[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
                jb[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
            end
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, l)) : -1;
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
            end
            run_job(l, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ab, res, ovf, got, lat, sawr);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
